// File: rtl/xkeyfifo_pkg.sv
// Shared definitions for the PS/2 keypad FIFO: scancode prefixes, key codes,
// decoder state encoding, KEY/STATUS register bit positions and base address.
// Latency: n/a (definitions only).  Backpressure: n/a.
package xkeyfifo_pkg;

    // Bus base address of the KEY (offset 0) / STATUS (offset 1) pair.
    localparam logic [31:0] KEYFIFO_BASE = 32'h0000_4000;

    // Set-2 prefix bytes.
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Key codes; digits 0..9 map to 5'h00..5'h09.
    localparam logic [4:0] KC_PLUS  = 5'h0A;
    localparam logic [4:0] KC_MINUS = 5'h0B;
    localparam logic [4:0] KC_MUL   = 5'h0C;
    localparam logic [4:0] KC_DIV   = 5'h0D;
    localparam logic [4:0] KC_ENTER = 5'h0E;
    localparam logic [4:0] KC_BKSP  = 5'h0F;
    localparam logic [4:0] KC_CLEAR = 5'h10;

    // Scancode decoder states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // KEY register layout.
    localparam int KEY_VALID_BIT = 8;
    localparam int KEY_REL_BIT   = 7;

    // STATUS register layout (read).
    localparam int ST_NEMPTY_BIT = 0;
    localparam int ST_FULL_BIT   = 1;
    localparam int ST_OVF_BIT    = 2;
    localparam int ST_CNT_LSB    = 4;
    localparam int ST_CNT_W      = 5;

    // STATUS register layout (write).
    localparam int CTL_FLUSH_BIT   = 0;
    localparam int CTL_OVF_CLR_BIT = 2;

    // One FIFO entry.
    typedef struct packed {
        logic       rel;
        logic [4:0] code;
    } key_entry_t;

endpackage

// File: rtl/xkeymap.sv
// Scancode translator: set-2 byte plus extended flag -> {hit, code[4:0]}.
// Latency: purely combinational.  Backpressure: none.
// Ports: scancode/extended in; hit (key is mapped) and code out.
module xkeymap
    import xkeyfifo_pkg::*;
(
    input  logic [7:0] scancode,
    input  logic       extended,
    output logic       hit,
    output logic [4:0] code
);

    always_comb begin
        hit  = 1'b1;
        code = 5'h00;
        if (extended) begin
            // Only the keypad '/' and keypad Enter carry an E0 prefix here.
            case (scancode)
                8'h4A:   code = KC_DIV;
                8'h5A:   code = KC_ENTER;
                default: hit  = 1'b0;
            endcase
        end else begin
            case (scancode)
                8'h45, 8'h70: code = 5'd0;
                8'h16, 8'h69: code = 5'd1;
                8'h1E, 8'h72: code = 5'd2;
                8'h26, 8'h7A: code = 5'd3;
                8'h25, 8'h6B: code = 5'd4;
                8'h2E, 8'h73: code = 5'd5;
                8'h36, 8'h74: code = 5'd6;
                8'h3D, 8'h6C: code = 5'd7;
                8'h3E, 8'h75: code = 5'd8;
                8'h46, 8'h7D: code = 5'd9;
                8'h79:        code = KC_PLUS;
                8'h7B:        code = KC_MINUS;
                8'h7C:        code = KC_MUL;
                8'h5A:        code = KC_ENTER;
                8'h66:        code = KC_BKSP;
                8'h76:        code = KC_CLEAR;
                default:      hit  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/xkeyfifo.sv
// PS/2 keypad front end: set-2 prefix decoder feeding a key FIFO behind a 2-register bus.
// Latency: mapped key enters the FIFO on the edge that samples its final byte; reads are combinational.
// Backpressure: none upstream; a push into a full FIFO (without a pop that cycle) is dropped and sets sticky overflow.
// Ports: clk, rst (sync, active-high); byte_in/byte_valid from the PS/2 receiver;
//        sel/we/addr/data_in/data_out bus (addr 0 = KEY, pop on read; addr 1 = STATUS, write flush/clear).
// Build option: KEYFIFO_RELEASE_EN defined -> mapped key releases are queued with release=1.
module xkeyfifo
    import xkeyfifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sel,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Scancode prefix decoder
    // ------------------------------------------------------------------
    dec_state_t state_q, state_d;
    logic       xlate_vld;
    logic       xlate_ext;
    logic       xlate_rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        xlate_vld = 1'b0;
        xlate_ext = 1'b0;
        xlate_rel = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_in == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        xlate_vld = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_in == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        xlate_vld = 1'b1;
                        xlate_ext = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    xlate_vld = 1'b1;
                    xlate_rel = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    xlate_vld = 1'b1;
                    xlate_ext = 1'b1;
                    xlate_rel = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic       map_hit;
    logic [4:0] map_code;

    xkeymap u_map (
        .scancode (byte_in),
        .extended (xlate_ext),
        .hit      (map_hit),
        .code     (map_code)
    );

    logic       push_vld;
    key_entry_t push_dat;

`ifdef KEYFIFO_RELEASE_EN
    assign push_vld = xlate_vld & map_hit;
    assign push_dat = '{rel: xlate_rel, code: map_code};
`else
    // Releases are still walked through the decoder so the prefix state stays
    // in step, but they never reach the FIFO.
    assign push_vld = xlate_vld & map_hit & ~xlate_rel;
    assign push_dat = '{rel: 1'b0, code: map_code};
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic key_rd;
    logic st_wr;
    logic flush;
    logic ovf_clr;
    logic unused_data_in;

    assign key_rd         = sel & ~we & ~addr;
    assign st_wr          = sel & we & addr;
    assign flush          = st_wr & data_in[CTL_FLUSH_BIT];
    assign ovf_clr        = st_wr & data_in[CTL_OVF_CLR_BIT];
    assign unused_data_in = ^{data_in[31:3], data_in[1]};

    // ------------------------------------------------------------------
    // Key FIFO
    // ------------------------------------------------------------------
    key_entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   overflow;
    logic                   empty;
    logic                   full;
    logic                   do_pop;
    logic                   do_push;
    key_entry_t             head;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = key_rd & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push = push_vld & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Software clear has priority over a drop in the same cycle; a drop that
    // coincides with a flush is not an overflow since the FIFO empties anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else if (push_vld && full && !do_pop && !flush) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        data_out = '0;
        if (!addr) begin
            if (!empty) begin
                data_out[KEY_VALID_BIT] = 1'b1;
                data_out[KEY_REL_BIT]   = head.rel;
                data_out[4:0]           = head.code;
            end
        end else begin
            data_out[ST_NEMPTY_BIT]               = ~empty;
            data_out[ST_FULL_BIT]                 = full;
            data_out[ST_OVF_BIT]                  = overflow;
            data_out[ST_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(count);
        end
    end

endmodule

// File: tb/tb_xkeyfifo.sv
module tb_xkeyfifo;

    localparam int DEPTH = 8;
`ifdef KEYFIFO_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        sel;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    always #5 clk = ~clk;

    xkeyfifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of expected KEY read values plus prefix flags.
    logic [31:0] mq[$];
    bit          m_ovf;
    bit          m_ext;
    bit          m_brk;

    localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] PAD [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                        8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    localparam logic [7:0] OPS [7]  = '{8'h79, 8'h7B, 8'h7C, 8'h5A, 8'h66, 8'h76, 8'h4A};

    function automatic int xlate(bit ext, logic [7:0] b);
        if (ext) begin
            if (b == 8'h4A) return 13;
            if (b == 8'h5A) return 14;
            return -1;
        end
        for (int i = 0; i < 10; i++) begin
            if (b == DIG[i] || b == PAD[i]) return i;
        end
        case (b)
            8'h79:   return 10;
            8'h7B:   return 11;
            8'h7C:   return 12;
            8'h5A:   return 14;
            8'h66:   return 15;
            8'h76:   return 16;
            default: return -1;
        endcase
    endfunction

    function automatic void model_byte(logic [7:0] b, bit flushing);
        int c;
        bit rel;
        if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1'b1;
        end else begin
            c     = xlate(m_ext, b);
            rel   = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
            if (c >= 0 && (REL_EN || !rel) && !flushing) begin
                if (mq.size() < DEPTH) mq.push_back(32'h100 | (rel ? 32'h80 : 32'h0) | 32'(c));
                else m_ovf = 1'b1;
            end
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    function automatic logic [31:0] model_key();
        return (mq.size() > 0) ? mq[0] : 32'h0;
    endfunction

    function automatic logic [31:0] model_status();
        int n = mq.size();
        return 32'((n != 0) ? 1 : 0) | 32'((n == DEPTH) ? 2 : 0) |
               32'(m_ovf ? 4 : 0) | 32'(n << 4);
    endfunction

    // One bus/byte cycle: inputs applied after a falling edge, data_out sampled
    // 1 ns later, model updated once the rising edge has passed.
    task automatic cycle(input bit bv, input logic [7:0] b, input bit s, input bit w,
                         input bit a, input logic [31:0] d, output logic [31:0] obs);
        bit pop;
        bit wr_st;
        byte_valid = bv;
        byte_in    = b;
        sel        = s;
        we         = w;
        addr       = a;
        data_in    = d;
        #1 obs = data_out;
        @(negedge clk);
        pop   = s && !w && !a && (mq.size() > 0);
        wr_st = s && w && a;
        if (pop) void'(mq.pop_front());
        if (bv) model_byte(b, wr_st && d[0]);
        if (wr_st && d[2]) m_ovf = 1'b0;
        if (wr_st && d[0]) mq.delete();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        sel        = 1'b0;
        we         = 1'b0;
        addr       = 1'b0;
        data_in    = 32'h0;
    endtask

    task automatic send(input logic [7:0] b);
        logic [31:0] dummy;
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0, 32'h0, dummy);
    endtask

    task automatic key_read(output logic [31:0] obs);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, obs);
    endtask

    task automatic status_read(output logic [31:0] obs);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0, obs);
    endtask

    task automatic status_write(input logic [31:0] v);
        logic [31:0] dummy;
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, v, dummy);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] obs;
        apply_reset(3);
        addr = 1'b0;
        #1 obs = data_out;
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL reset_key got=%h exp=%h", obs, 32'h0); failures++;
        end
        status_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL reset_status got=%h exp=%h", obs, 32'h0); failures++;
        end
    endtask

    task automatic test_make_break();
        logic [31:0] obs;
        send(8'h16); send(8'hF0); send(8'h16);
        key_read(obs);
        checks++;
        if (obs !== 32'h101) begin
            $display("FAIL make_1 got=%h exp=%h", obs, 32'h101); failures++;
        end
        key_read(obs);
        checks++;
        if (obs !== (REL_EN ? 32'h181 : 32'h0)) begin
            $display("FAIL release_1 got=%h exp=%h", obs, REL_EN ? 32'h181 : 32'h0); failures++;
        end
    endtask

    task automatic test_extended();
        logic [31:0] obs;
        logic [31:0] exp;
        send(8'hE0); send(8'h4A);
        key_read(obs);
        checks++;
        if (obs !== 32'h10D) begin
            $display("FAIL ext_div got=%h exp=%h", obs, 32'h10D); failures++;
        end
        send(8'hE0); send(8'hF0); send(8'h4A);
        key_read(obs);
        checks++;
        if (obs !== (REL_EN ? 32'h18D : 32'h0)) begin
            $display("FAIL ext_div_rel got=%h exp=%h", obs, REL_EN ? 32'h18D : 32'h0); failures++;
        end
        // Both Enter forms, then an unmapped extended key and a typematic repeat.
        send(8'hE0); send(8'h5A); send(8'h5A); send(8'hE0); send(8'h70);
        send(8'h7C); send(8'h7C);
        for (int i = 0; i < 5; i++) begin
            exp = model_key();
            key_read(obs);
            checks++;
            if (obs !== exp) begin
                $display("FAIL ext_seq[%0d] got=%h exp=%h", i, obs, exp); failures++;
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] obs;
        status_write(32'h5);
        for (int i = 0; i < 9; i++) send(8'h45);
        status_read(obs);
        checks++;
        if (obs !== 32'h087) begin
            $display("FAIL ovf_status got=%h exp=%h", obs, 32'h087); failures++;
        end
        status_write(32'h4);
        status_read(obs);
        checks++;
        if (obs !== 32'h083) begin
            $display("FAIL ovf_clear got=%h exp=%h", obs, 32'h083); failures++;
        end
        key_read(obs);
        checks++;
        if (obs !== 32'h100) begin
            $display("FAIL ovf_head got=%h exp=%h", obs, 32'h100); failures++;
        end
        status_write(32'h1);
        status_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL flush got=%h exp=%h", obs, 32'h0); failures++;
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] obs;
        logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) send(DIG[i]);
        // Byte 1E arrives on the same edge as a KEY read of the full FIFO.
        cycle(1'b1, 8'h1E, 1'b1, 1'b0, 1'b0, 32'h0, obs);
        checks++;
        if (obs !== 32'h100) begin
            $display("FAIL full_pop_head got=%h exp=%h", obs, 32'h100); failures++;
        end
        status_read(obs);
        checks++;
        if (obs !== 32'h083) begin
            $display("FAIL full_pop_status got=%h exp=%h", obs, 32'h083); failures++;
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            exp = model_key();
            key_read(obs);
            checks++;
            if (obs !== exp) begin
                $display("FAIL full_drain[%0d] got=%h exp=%h", i, obs, exp); failures++;
            end
        end
        key_read(obs);
        checks++;
        if (obs !== 32'h102) begin
            $display("FAIL full_last got=%h exp=%h", obs, 32'h102); failures++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs;
        send(8'h0D);
        send(8'hE0);
        apply_reset(1);
        send(8'h3D);
        key_read(obs);
        checks++;
        if (obs !== 32'h107) begin
            $display("FAIL rst_mid_key got=%h exp=%h", obs, 32'h107); failures++;
        end
        status_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL rst_mid_empty got=%h exp=%h", obs, 32'h0); failures++;
        end
    endtask

    task automatic test_empty_read();
        logic [31:0] obs;
        key_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL empty_key got=%h exp=%h", obs, 32'h0); failures++;
        end
        status_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL empty_status got=%h exp=%h", obs, 32'h0); failures++;
        end
    endtask

    task automatic test_flush_push();
        logic [31:0] obs;
        logic [31:0] dummy;
        send(8'h16); send(8'h26);
        cycle(1'b1, 8'h1E, 1'b1, 1'b1, 1'b1, 32'h1, dummy);
        status_read(obs);
        checks++;
        if (obs !== 32'h0) begin
            $display("FAIL flush_push got=%h exp=%h", obs, 32'h0); failures++;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 15) return 8'hE0;
        if (r < 35) return 8'hF0;
        if (r < 60) return DIG[$urandom_range(0, 9)];
        if (r < 75) return PAD[$urandom_range(0, 9)];
        if (r < 85) return OPS[$urandom_range(0, 6)];
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        logic [31:0] obs;
        logic [31:0] exp;
        logic [31:0] dummy;
        bit          bv;
        bit          rd;
        logic [7:0]  b;
        apply_reset(1);
        for (int i = 0; i < 600; i++) begin
            bv = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 2) == 0);
            b  = rand_byte();
            if (rd) begin
                exp = model_key();
                cycle(bv, b, 1'b1, 1'b0, 1'b0, 32'h0, obs);
                checks++;
                if (obs !== exp) begin
                    $display("FAIL rand_key[%0d] got=%h exp=%h", i, obs, exp); failures++;
                end
            end else begin
                cycle(bv, b, 1'b0, 1'b0, 1'b0, 32'h0, dummy);
            end
            if (i % 25 == 24) begin
                exp = model_status();
                status_read(obs);
                checks++;
                if (obs !== exp) begin
                    $display("FAIL rand_status[%0d] got=%h exp=%h", i, obs, exp); failures++;
                end
                if (m_ovf) status_write(32'h4);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sel        = 1'b0;
        we         = 1'b0;
        addr       = 1'b0;
        data_in    = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_make_break();
        test_extended();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_empty_read();
        test_flush_push();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
